axis_merge: RTL

Packs pairs of consecutive narrow AXI-Stream beats into one double-width beat. It is the inverse stage of the stream splitter and sits downstream of it, on the receiving side of a narrow link, to restore the original wide stream. The output is fully registered. Input runs at one narrow beat per cycle with no bubbles while the output drains.

---
 rtl/axis_merge_if.sv | 29 ++
 rtl/axis_merge.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/axis_merge_if.sv
// AXI-Stream bundle used on both sides of axis_merge.
// The data width is set per instance; strobes follow at one bit per byte.
interface axis_merge_if #(
  parameter int DATA_WIDTH = 16
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [STRB_WIDTH-1:0] tstrb;
  logic                  tlast;

  modport master (
    output tvalid,
    output tdata,
    output tstrb,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tstrb,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_merge.sv
// axis_merge: packs pairs of consecutive narrow AXI-Stream beats into one
// double-width beat with a fully registered output.
// Optional feature macro AXIS_MERGE_TLAST_EN: honours s_axis.tlast so a
// packet ending on a first half is flushed zero-padded with tlast set.
module axis_merge #(
  parameter int C_S_AXIS_TDATA_WIDTH = 16,
  parameter int C_M_AXIS_TDATA_WIDTH = 2 * C_S_AXIS_TDATA_WIDTH,
  parameter bit MSH_FIRST            = 1'b1
) (
  input  logic         axis_aclk,
  input  logic         axis_aresetn,
  axis_merge_if.slave  s_axis,
  axis_merge_if.master m_axis
);

  localparam int SW  = C_S_AXIS_TDATA_WIDTH;
  localparam int MW  = C_M_AXIS_TDATA_WIDTH;
  localparam int SSW = SW / 8;
  localparam int MSW = MW / 8;

  typedef enum logic {
    FIRST = 1'b0,
    LAST  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    halfData_q, halfData_d;
  logic [SSW-1:0]   halfStrb_q, halfStrb_d;
  logic             outValid_q;
  logic [MW-1:0]    outData_q;
  logic [MSW-1:0]   outStrb_q;
  logic             outLast_q;

  logic             outFree;
  logic             sReady;
  logic             sHandshake;
  logic             mHandshake;
  logic             load;
  logic [MW-1:0]    loadData;
  logic [MSW-1:0]   loadStrb;
  logic             loadLast;

  assign outFree    = ~outValid_q | m_axis.tready;
  assign sHandshake = s_axis.tvalid & sReady;
  assign mHandshake = outValid_q & m_axis.tready;

`ifndef AXIS_MERGE_TLAST_EN
  logic unusedTlast;
  assign unusedTlast = s_axis.tlast;
`endif

  // Input ready: the second half needs room in the output register; never ready in reset.
  always_comb begin
    sReady = 1'b0;
    case (state_q)
`ifdef AXIS_MERGE_TLAST_EN
      FIRST:   sReady = outFree;
`else
      FIRST:   sReady = 1'b1;
`endif
      LAST:    sReady = outFree;
      default: sReady = 1'b0;
    endcase
    sReady = sReady & axis_aresetn;
  end

  // Pairing FSM: capture the first half, then build the wide beat on the second.
  always_comb begin
    state_d    = state_q;
    halfData_d = halfData_q;
    halfStrb_d = halfStrb_q;
    load       = 1'b0;
    loadData   = '0;
    loadStrb   = '0;
    loadLast   = 1'b0;
    case (state_q)
      FIRST: begin
        if (sHandshake) begin
`ifdef AXIS_MERGE_TLAST_EN
          if (s_axis.tlast) begin
            load     = 1'b1;
            loadLast = 1'b1;
            if (MSH_FIRST) begin
              loadData = {s_axis.tdata, {SW{1'b0}}};
              loadStrb = {s_axis.tstrb, {SSW{1'b0}}};
            end else begin
              loadData = {{SW{1'b0}}, s_axis.tdata};
              loadStrb = {{SSW{1'b0}}, s_axis.tstrb};
            end
          end else begin
            halfData_d = s_axis.tdata;
            halfStrb_d = s_axis.tstrb;
            state_d    = LAST;
          end
`else
          halfData_d = s_axis.tdata;
          halfStrb_d = s_axis.tstrb;
          state_d    = LAST;
`endif
        end
      end
      LAST: begin
        if (sHandshake) begin
          load    = 1'b1;
          state_d = FIRST;
`ifdef AXIS_MERGE_TLAST_EN
          loadLast = s_axis.tlast;
`endif
          if (MSH_FIRST) begin
            loadData = {halfData_q, s_axis.tdata};
            loadStrb = {halfStrb_q, s_axis.tstrb};
          end else begin
            loadData = {s_axis.tdata, halfData_q};
            loadStrb = {s_axis.tstrb, halfStrb_q};
          end
        end
      end
      default: state_d = FIRST;
    endcase
  end

  // State and half register; reset drops any held first half.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q    <= FIRST;
      halfData_q <= '0;
      halfStrb_q <= '0;
    end else begin
      state_q    <= state_d;
      halfData_q <= halfData_d;
      halfStrb_q <= halfStrb_d;
    end
  end

  // Output register: a load wins over a drain so back-to-back beats stay valid.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outStrb_q  <= '0;
      outLast_q  <= 1'b0;
    end else if (load) begin
      outValid_q <= 1'b1;
      outData_q  <= loadData;
      outStrb_q  <= loadStrb;
      outLast_q  <= loadLast;
    end else if (mHandshake) begin
      outValid_q <= 1'b0;
    end
  end

  assign s_axis.tready = sReady;
  assign m_axis.tvalid = outValid_q;
  assign m_axis.tdata  = outData_q;
  assign m_axis.tstrb  = outStrb_q;
  assign m_axis.tlast  = outLast_q;

endmodule
